sva_delay_checker: RTL and testbench

- Parametrised multi-thread hardware checker for the property "antecedent |-> ##[DMIN:DMAX] consequent", evaluated directly on user clock gclk.
- Each sampled antecedent starts an attempt, held in a pool of NUM_THREADS slots. Every attempt ends as success, fail, dropped (pool full) or lazy (still pending at finish).
- Sits beside the DUT in the synthesised-assertion flow. Drives pulse flags plus saturating statistics that the bench or host reads.

---
 rtl/sva_delay_checker.sv | 217 +++++++++++++++++++++
 tb/tb_sva_delay_checker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sva_delay_checker.sv
// -----------------------------------------------------------------------------
// sva_delay_checker
//
// Synthesisable checker for "antecedent |-> ##[DMIN:DMAX] consequent" on gclk.
// Every sampled antecedent opens an attempt in one of NUM_THREADS slots. An
// attempt ends as success, fail, dropped (no slot free) or lazy (still open
// when finish is pulsed). Outcomes leave as one-cycle pulses plus saturating
// statistics. All outputs are registered.
//
// Ports
//   gclk             in   user clock, posedge sampling
//   grst             in   asynchronous active-high reset
//   en               in   allows new attempts; open attempts keep evaluating
//   antecedent       in   property antecedent
//   consequent       in   property consequent
//   finish           in   end-of-test pulse: counts and clears open attempts
//   succ             out  pulse: >=1 attempt succeeded at the last edge
//   fail             out  pulse: >=1 attempt failed at the last edge
//   overflow         out  pulse: an attempt was dropped at the last edge
//   busy             out  at least one slot open
//   succ_cnt         out  saturating success count
//   fail_cnt         out  saturating failure count
//   drop_cnt         out  saturating dropped-attempt count
//   lazy_cnt         out  open slots at the last finish
//   first_fail_valid out  sticky: a failure has been seen
//   first_fail_time  out  spawn timestamp of the first failed attempt
// -----------------------------------------------------------------------------
module sva_delay_checker #(
  parameter int NUM_THREADS = 4,
  parameter int DMIN        = 1,
  parameter int DMAX        = 3,
  parameter int CNT_W       = 16,
  parameter int TIME_W      = 32
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              en,
  input  logic              antecedent,
  input  logic              consequent,
  input  logic              finish,
  output logic              succ,
  output logic              fail,
  output logic              overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  succ_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  lazy_cnt,
  output logic              first_fail_valid,
  output logic [TIME_W-1:0] first_fail_time
);

  localparam int AGE_W    = $clog2(DMAX + 1) + 1;
  localparam int AGE_N    = 1 << AGE_W;
  // Wide enough for a popcount of all slots plus one immediate success.
  localparam int PC_W     = $clog2(NUM_THREADS + 2) + 1;
  localparam int SUM_W    = CNT_W + PC_W;
  localparam bit ZERO_MIN = (DMIN == 0);

  // Lookup of "age has reached DMIN", built at elaboration so the run-time
  // compare never degenerates into an always-true test when DMIN is 0.
  function automatic logic [AGE_N-1:0] min_ok_table();
    logic [AGE_N-1:0] t;
    for (int j = 0; j < AGE_N; j++) begin
      t[j] = (j >= DMIN);
    end
    return t;
  endfunction

  localparam logic [AGE_N-1:0] MIN_OK = min_ok_table();
  localparam logic [AGE_W-1:0] DMAX_A = AGE_W'(DMAX);

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_THREADS-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < NUM_THREADS; i++) begin
      c = c + {{(PC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    return (s > {{PC_W{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Slot state and timestamp
  logic [NUM_THREADS-1:0] act_r;
  logic [AGE_W-1:0]       age_r [NUM_THREADS];
  logic [TIME_W-1:0]      ts_r  [NUM_THREADS];
  logic [TIME_W-1:0]      timer_r;

  // Per-edge decisions
  logic [AGE_W-1:0]       age_inc_s [NUM_THREADS];
  logic [NUM_THREADS-1:0] succ_v_s;
  logic [NUM_THREADS-1:0] fail_v_s;
  logic [NUM_THREADS-1:0] live_s;
  logic [NUM_THREADS-1:0] free_sel_s;
  logic                   free_found_s;
  logic                   spawn_req_s;
  logic                   imm_s;
  logic                   alloc_req_s;
  logic                   drop_s;
  logic [NUM_THREADS-1:0] take_s;
  logic [NUM_THREADS-1:0] act_nxt_s;
  logic [TIME_W-1:0]      fail_ts_s;
  logic [PC_W-1:0]        succ_pc_s;
  logic [PC_W-1:0]        fail_pc_s;
  logic [PC_W-1:0]        live_pc_s;

  // Ageing of open slots and their success/fail outcome at this edge.
  always_comb begin
    succ_v_s = {NUM_THREADS{1'b0}};
    fail_v_s = {NUM_THREADS{1'b0}};
    for (int i = 0; i < NUM_THREADS; i++) begin
      age_inc_s[i] = age_r[i] + {{(AGE_W-1){1'b0}}, 1'b1};
      succ_v_s[i]  = act_r[i] & MIN_OK[age_inc_s[i]] & consequent;
      // Success takes priority when the window closes on a consequent.
      fail_v_s[i]  = act_r[i] & ~succ_v_s[i] & (age_inc_s[i] == DMAX_A);
    end
    live_s = act_r & ~succ_v_s & ~fail_v_s;
  end

  // Spawn decision: only slots free before this edge may be taken, so a slot
  // retired at this edge stays unusable until the next one.
  always_comb begin
    free_sel_s   = {NUM_THREADS{1'b0}};
    free_found_s = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      free_sel_s[i] = ~act_r[i] & ~free_found_s;
      free_found_s  = free_found_s | ~act_r[i];
    end
    spawn_req_s = en & antecedent & ~finish;
    imm_s       = spawn_req_s & consequent & ZERO_MIN;
    alloc_req_s = spawn_req_s & ~imm_s;
    drop_s      = alloc_req_s & ~free_found_s;
    take_s      = free_sel_s & {NUM_THREADS{alloc_req_s}};
    act_nxt_s   = finish ? {NUM_THREADS{1'b0}} : (live_s | take_s);
  end

  // Timestamp of the lowest-index failing slot and outcome popcounts.
  always_comb begin
    fail_ts_s = {TIME_W{1'b0}};
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      fail_ts_s = fail_v_s[i] ? ts_r[i] : fail_ts_s;
    end
    succ_pc_s = popcount(succ_v_s) + {{(PC_W-1){1'b0}}, imm_s};
    fail_pc_s = popcount(fail_v_s);
    live_pc_s = popcount(live_s);
  end

  // Slot array and free-running timer.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      act_r   <= {NUM_THREADS{1'b0}};
      timer_r <= {TIME_W{1'b0}};
      for (int i = 0; i < NUM_THREADS; i++) begin
        age_r[i] <= {AGE_W{1'b0}};
        ts_r[i]  <= {TIME_W{1'b0}};
      end
    end else begin
      timer_r <= timer_r + {{(TIME_W-1){1'b0}}, 1'b1};
      act_r   <= act_nxt_s;
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (take_s[i]) begin
          age_r[i] <= {AGE_W{1'b0}};
          ts_r[i]  <= timer_r;
        end else if (act_r[i]) begin
          age_r[i] <= age_inc_s[i];
          ts_r[i]  <= ts_r[i];
        end else begin
          age_r[i] <= age_r[i];
          ts_r[i]  <= ts_r[i];
        end
      end
    end
  end

  // Registered pulses, statistics and first-failure capture.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      succ             <= 1'b0;
      fail             <= 1'b0;
      overflow         <= 1'b0;
      busy             <= 1'b0;
      succ_cnt         <= {CNT_W{1'b0}};
      fail_cnt         <= {CNT_W{1'b0}};
      drop_cnt         <= {CNT_W{1'b0}};
      lazy_cnt         <= {CNT_W{1'b0}};
      first_fail_valid <= 1'b0;
      first_fail_time  <= {TIME_W{1'b0}};
    end else begin
      succ     <= (|succ_v_s) | imm_s;
      fail     <= |fail_v_s;
      overflow <= drop_s;
      busy     <= |act_nxt_s;
      succ_cnt <= sat_add(succ_cnt, succ_pc_s);
      fail_cnt <= sat_add(fail_cnt, fail_pc_s);
      drop_cnt <= sat_add(drop_cnt, {{(PC_W-1){1'b0}}, drop_s});
      if (finish) begin
        lazy_cnt <= sat_add({CNT_W{1'b0}}, live_pc_s);
      end else begin
        lazy_cnt <= lazy_cnt;
      end
      if (!first_fail_valid && (|fail_v_s)) begin
        first_fail_valid <= 1'b1;
        first_fail_time  <= fail_ts_s;
      end else begin
        first_fail_valid <= first_fail_valid;
        first_fail_time  <= first_fail_time;
      end
    end
  end

endmodule

// File: tb/tb_sva_delay_checker.sv
// -----------------------------------------------------------------------------
// tb_sva_delay_checker
//
// Two checker instances share one stimulus stream:
//   A: NUM_THREADS=2, DMIN=1, DMAX=3, CNT_W=16
//   B: NUM_THREADS=3, DMIN=0, DMAX=2, CNT_W=2 (immediate success, saturation)
// A reference model tracks each attempt by the edge number it was spawned on
// and predicts the outputs after every edge; predictions are queued by the
// driver and consumed by an independent monitor. Directed scenarios add
// explicit constant checks.
// -----------------------------------------------------------------------------
module tb_sva_delay_checker;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  logic en = 1'b0, antecedent = 1'b0, consequent = 1'b0, finish = 1'b0;

  logic        a_succ, a_fail, a_overflow, a_busy, a_ffv;
  logic [15:0] a_succ_cnt, a_fail_cnt, a_drop_cnt, a_lazy_cnt;
  logic [31:0] a_fft;
  logic        b_succ, b_fail, b_overflow, b_busy, b_ffv;
  logic [1:0]  b_succ_cnt, b_fail_cnt, b_drop_cnt, b_lazy_cnt;
  logic [31:0] b_fft;

  always #5 gclk = ~gclk;

  sva_delay_checker #(.NUM_THREADS(2), .DMIN(1), .DMAX(3), .CNT_W(16), .TIME_W(32)) dut_a (
    .gclk(gclk), .grst(grst), .en(en), .antecedent(antecedent),
    .consequent(consequent), .finish(finish),
    .succ(a_succ), .fail(a_fail), .overflow(a_overflow), .busy(a_busy),
    .succ_cnt(a_succ_cnt), .fail_cnt(a_fail_cnt), .drop_cnt(a_drop_cnt),
    .lazy_cnt(a_lazy_cnt), .first_fail_valid(a_ffv), .first_fail_time(a_fft));

  sva_delay_checker #(.NUM_THREADS(3), .DMIN(0), .DMAX(2), .CNT_W(2), .TIME_W(32)) dut_b (
    .gclk(gclk), .grst(grst), .en(en), .antecedent(antecedent),
    .consequent(consequent), .finish(finish),
    .succ(b_succ), .fail(b_fail), .overflow(b_overflow), .busy(b_busy),
    .succ_cnt(b_succ_cnt), .fail_cnt(b_fail_cnt), .drop_cnt(b_drop_cnt),
    .lazy_cnt(b_lazy_cnt), .first_fail_valid(b_ffv), .first_fail_time(b_fft));

  typedef struct {
    bit     succ, fail, overflow, busy, ffv;
    longint succ_cnt, fail_cnt, drop_cnt, lazy_cnt, fft;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state, index 0 = instance A, 1 = instance B.
  int     m_nt[2]   = '{2, 3};
  int     m_dmin[2] = '{1, 0};
  int     m_dmax[2] = '{3, 2};
  longint m_cmax[2] = '{65535, 3};
  bit     m_act[2][4];
  longint m_spawn[2][4];
  longint m_succ[2], m_fail[2], m_drop[2], m_lazy[2], m_fft[2];
  bit     m_ffv[2];
  longint edge_n = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint sat(int id, longint v);
    return (v > m_cmax[id]) ? m_cmax[id] : v;
  endfunction

  function automatic void model_reset(int id);
    for (int s = 0; s < 4; s++) begin
      m_act[id][s]   = 1'b0;
      m_spawn[id][s] = 0;
    end
    m_succ[id] = 0; m_fail[id] = 0; m_drop[id] = 0; m_lazy[id] = 0;
    m_ffv[id]  = 1'b0; m_fft[id] = 0;
  endfunction

  // Predicts outputs after the edge numbered edge_n with the given inputs.
  function automatic exp_t model_step(int id, bit e, bit a, bit c, bit f);
    exp_t   r;
    int     ns = 0, nf = 0, pend = 0, slot = -1;
    longint fts = -1, age;
    bit     was_free[4];
    bit     ovf = 1'b0, any = 1'b0;
    for (int s = 0; s < m_nt[id]; s++) begin
      was_free[s] = !m_act[id][s];
      if (m_act[id][s]) begin
        age = edge_n - m_spawn[id][s];
        if (age >= m_dmin[id] && c) begin
          ns++;
          m_act[id][s] = 1'b0;
        end else if (age == m_dmax[id]) begin
          nf++;
          if (fts < 0) fts = m_spawn[id][s];
          m_act[id][s] = 1'b0;
        end
      end
    end
    if (f) begin
      for (int s = 0; s < m_nt[id]; s++) begin
        if (m_act[id][s]) pend++;
        m_act[id][s] = 1'b0;
      end
      m_lazy[id] = sat(id, pend);
    end else if (e && a) begin
      if (m_dmin[id] == 0 && c) begin
        ns++;
      end else begin
        for (int s = 0; s < m_nt[id]; s++) begin
          if (was_free[s] && slot < 0) slot = s;
        end
        if (slot >= 0) begin
          m_act[id][slot]   = 1'b1;
          m_spawn[id][slot] = edge_n;
        end else begin
          ovf = 1'b1;
          m_drop[id] = sat(id, m_drop[id] + 1);
        end
      end
    end
    m_succ[id] = sat(id, m_succ[id] + ns);
    m_fail[id] = sat(id, m_fail[id] + nf);
    if (nf > 0 && !m_ffv[id]) begin
      m_ffv[id] = 1'b1;
      m_fft[id] = fts;
    end
    for (int s = 0; s < m_nt[id]; s++) any |= m_act[id][s];
    r.succ = (ns > 0); r.fail = (nf > 0); r.overflow = ovf; r.busy = any;
    r.succ_cnt = m_succ[id]; r.fail_cnt = m_fail[id];
    r.drop_cnt = m_drop[id]; r.lazy_cnt = m_lazy[id];
    r.ffv = m_ffv[id]; r.fft = m_fft[id];
    return r;
  endfunction

  function automatic void compare(string tag, exp_t x, bit s, bit f, bit o, bit b,
                                  longint sc, longint fc, longint dc, longint lc,
                                  bit v, longint ft);
    check({tag, "_succ"}, longint'(s), longint'(x.succ));
    check({tag, "_fail"}, longint'(f), longint'(x.fail));
    check({tag, "_overflow"}, longint'(o), longint'(x.overflow));
    check({tag, "_busy"}, longint'(b), longint'(x.busy));
    check({tag, "_succ_cnt"}, sc, x.succ_cnt);
    check({tag, "_fail_cnt"}, fc, x.fail_cnt);
    check({tag, "_drop_cnt"}, dc, x.drop_cnt);
    check({tag, "_lazy_cnt"}, lc, x.lazy_cnt);
    check({tag, "_first_fail_valid"}, longint'(v), longint'(x.ffv));
    check({tag, "_first_fail_time"}, ft, x.fft);
  endfunction

  function automatic void compare_a(string tag, exp_t x);
    compare(tag, x, a_succ, a_fail, a_overflow, a_busy, longint'(a_succ_cnt),
            longint'(a_fail_cnt), longint'(a_drop_cnt), longint'(a_lazy_cnt),
            a_ffv, longint'(a_fft));
  endfunction

  function automatic void compare_b(string tag, exp_t x);
    compare(tag, x, b_succ, b_fail, b_overflow, b_busy, longint'(b_succ_cnt),
            longint'(b_fail_cnt), longint'(b_drop_cnt), longint'(b_lazy_cnt),
            b_ffv, longint'(b_fft));
  endfunction

  // Monitor: consumes one prediction per instance after every edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge gclk);
      #1;
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        compare_a("A", ea);
      end
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        compare_b("B", eb);
      end
    end
  end

  // Applies inputs for the next edge and queues the predicted outcome.
  task automatic drive(bit e, bit a, bit c, bit f);
    @(negedge gclk);
    if (grst) begin
      grst = 1'b0;
      model_reset(0);
      model_reset(1);
      edge_n = 0;
    end
    en = e; antecedent = a; consequent = c; finish = f;
    q_a.push_back(model_step(0, e, a, c, f));
    q_b.push_back(model_step(1, e, a, c, f));
    edge_n++;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    exp_t z;
    z = '{default: 0};
    @(negedge gclk);
    grst = 1'b1;
    en = 1'b0; antecedent = 1'b0; consequent = 1'b0; finish = 1'b0;
    #1;
    compare_a("A_reset", z);
    compare_b("B_reset", z);
  endtask

  task automatic settle();
    @(posedge gclk);
    #2;
  endtask

  initial begin
    // Single attempt satisfied at delay 2.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check("s1_succ", longint'(a_succ), 1);
    check("s1_succ_cnt", longint'(a_succ_cnt), 1);
    check("s1_fail_cnt", longint'(a_fail_cnt), 0);
    check("s1_busy", longint'(a_busy), 0);

    // Attempt at edge 5 times out at edge 8.
    do_reset();
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("s2_fail", longint'(a_fail), 1);
    check("s2_fail_cnt", longint'(a_fail_cnt), 1);
    check("s2_ffv", longint'(a_ffv), 1);
    check("s2_fft", longint'(a_fft), 5);

    // Third back-to-back attempt overflows the two-slot pool.
    do_reset();
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("s3_overflow", longint'(a_overflow), 1);
    check("s3_drop_cnt", longint'(a_drop_cnt), 1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("s3_fail_cnt", longint'(a_fail_cnt), 2);

    // Two attempts resolved by one consequent: one pulse, two counts.
    do_reset();
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check("s4_succ", longint'(a_succ), 1);
    check("s4_succ_cnt", longint'(a_succ_cnt), 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("s4_succ_pulse_end", longint'(a_succ), 0);

    // finish with two pending attempts, then a late consequent.
    do_reset();
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("s5_lazy_cnt", longint'(a_lazy_cnt), 2);
    check("s5_busy", longint'(a_busy), 0);
    check("s5_succ", longint'(a_succ), 0);
    check("s5_fail", longint'(a_fail), 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check("s5_late_succ", longint'(a_succ), 0);
    check("s5_late_succ_cnt", longint'(a_succ_cnt), 0);

    // DMIN=0 immediate success and CNT_W=2 saturation on instance B.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    check("s6_b_succ", longint'(b_succ), 1);
    check("s6_b_busy", longint'(b_busy), 0);
    check("s6_b_succ_cnt", longint'(b_succ_cnt), 1);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    check("s6_b_succ_cnt_sat", longint'(b_succ_cnt), 3);

    // Randomised traffic with occasional finish and mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      end
    end

    settle();
    #3;
    check("queue_drain", longint'(q_a.size() + q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
